// File: rtl/ext_int_ctrl_pkg.sv
// ext_int_ctrl_pkg
//   Shared constants and types for the external interrupt front end.
//   VecSize / VecT describe the CLIC vector index space; the ExtInt*
//   constants are the default configuration of ext_int_ctrl.
//   Build option: EXT_INT_DEBOUNCE_EN (see ext_int_filter).
package ext_int_ctrl_pkg;

  localparam int VecSize = 64;
  localparam int VecW    = $clog2(VecSize);
  typedef logic [VecW-1:0] VecT;

  localparam int ExtIntNum      = 4;
  localparam int ExtIntFirstId  = 1;
  localparam int ExtIntDebounce = 16;

  // Wrap an index into 0..n-1 (round-robin search and pointer update).
  function automatic int rr_wrap(input int idx, input int n);
    return (n > 0) ? (idx % n) : 0;
  endfunction

endpackage

// File: rtl/ext_int_filter.sv
// ext_int_filter
//   One external request line: two-flop synchronizer followed by the
//   filtered level. With EXT_INT_DEBOUNCE_EN defined, the level only
//   follows the synchronized input after it has differed from the current
//   level for DebounceCycles-1 consecutive cycles; otherwise level = s2.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-high reset
//   src_in  in   raw asynchronous request line
//   level   out  synchronized (and optionally debounced) level
module ext_int_filter
  import ext_int_ctrl_pkg::*;
#(
  parameter int DebounceCycles = ExtIntDebounce
) (
  input  logic clk,
  input  logic reset,
  input  logic src_in,
  output logic level
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= src_in;
      s2_q <= s1_q;
    end
  end

`ifdef EXT_INT_DEBOUNCE_EN
  localparam int CntW = $clog2(DebounceCycles);
  // The count is compared before incrementing, so firing on DebounceCycles-2
  // means the level flips on the (DebounceCycles-1)th consecutive mismatch.
  localparam logic [CntW-1:0] FireCnt = CntW'(DebounceCycles - 2);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (s2_q != level_q) begin
      if (cnt_q == FireCnt) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  // Debounce depth has no meaning without the counters.
  logic unused_db;
  assign unused_db = (DebounceCycles > 1);
  assign level     = s2_q;
`endif

endmodule

// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl
//   Multi-source external interrupt front end for the CLIC. Each source is
//   filtered (ext_int_filter), rising edges are latched as pending requests
//   and a round-robin arbiter issues one pend command at a time over a
//   valid/ready handshake. Edges that hit an already latched request set a
//   sticky overrun bit instead of being dropped silently.
//   Build option: EXT_INT_DEBOUNCE_EN enables per-source debounce counters.
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   src_in         in   raw request lines [NumSrc]
//   src_mask       in   1 = latch edges of that source [NumSrc]
//   pend_valid     out  pend command available
//   pend_id        out  CLIC vector index to pend (VecT)
//   pend_ready     in   CLIC accepts the command this cycle
//   overrun        out  sticky per-source overrun [NumSrc]
//   overrun_clear  in   clears matching overrun bits [NumSrc]
module ext_int_ctrl
  import ext_int_ctrl_pkg::*;
#(
  parameter int NumSrc         = ExtIntNum,
  parameter int FirstId        = ExtIntFirstId,
  parameter int DebounceCycles = ExtIntDebounce
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NumSrc-1:0] src_in,
  input  logic [NumSrc-1:0] src_mask,
  output logic              pend_valid,
  output logic [VecW-1:0]   pend_id,
  input  logic              pend_ready,
  output logic [NumSrc-1:0] overrun,
  input  logic [NumSrc-1:0] overrun_clear
);

  localparam int PtrW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

  logic [NumSrc-1:0] f;
  logic [NumSrc-1:0] f_q;
  logic [NumSrc-1:0] rise;
  logic [NumSrc-1:0] latch;
  logic [NumSrc-1:0] req_q, req_d;
  logic [NumSrc-1:0] ovr_q, ovr_d;
  logic [NumSrc-1:0] gnt_oh;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   gnt_idx;
  logic [PtrW-1:0]   cand;
  logic              found;
  logic              idle;
  logic              pend_valid_q, pend_valid_d;
  VecT               pend_id_q, pend_id_d;

  genvar gi;
  generate
    for (gi = 0; gi < NumSrc; gi++) begin : g_src
      ext_int_filter #(
        .DebounceCycles(DebounceCycles)
      ) u_filter (
        .clk   (clk),
        .reset (reset),
        .src_in(src_in[gi]),
        .level (f[gi])
      );
    end
  endgenerate

  assign rise  = f & ~f_q;
  assign latch = rise & src_mask;
  // The output register can take a new command when empty or being consumed.
  assign idle  = !pend_valid_q || pend_ready;

  // Round-robin pick among latched requests, starting at rr_ptr.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    gnt_oh  = '0;
    for (int k = 0; k < NumSrc; k++) begin
      cand = PtrW'(rr_wrap(int'(rr_ptr_q) + k, NumSrc));
      if (!found && req_q[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (idle && found) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    // A grant and a fresh edge on the same source leave the request set.
    req_d        = (req_q & ~gnt_oh) | latch;
    // Set has priority over clear on the same bit.
    ovr_d        = (ovr_q & ~overrun_clear) | (latch & req_q & ~gnt_oh);
    pend_valid_d = pend_valid_q;
    pend_id_d    = pend_id_q;
    rr_ptr_d     = rr_ptr_q;
    if (idle) begin
      pend_valid_d = found;
      if (found) begin
        pend_id_d = VecW'(FirstId) + VecW'(gnt_idx);
        rr_ptr_d  = PtrW'(rr_wrap(int'(gnt_idx) + 1, NumSrc));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q          <= '0;
      req_q        <= '0;
      ovr_q        <= '0;
      rr_ptr_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_id_q    <= '0;
    end else begin
      f_q          <= f;
      req_q        <= req_d;
      ovr_q        <= ovr_d;
      rr_ptr_q     <= rr_ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
    end
  end

  assign pend_valid = pend_valid_q;
  assign pend_id    = pend_id_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// tb_ext_int_ctrl
//   Self-checking bench for ext_int_ctrl: a table for the basic latency case,
//   hand-written sequences for arbitration, overrun, masking and reset, and a
//   randomized phase, all checked every cycle against a behavioural model.
//   Honours EXT_INT_DEBOUNCE_EN for latency expectations.
module tb_ext_int_ctrl;
  import ext_int_ctrl_pkg::*;

  localparam int N     = 4;
  localparam int FIRST = 1;
  localparam int DB    = 16;
`ifdef EXT_INT_DEBOUNCE_EN
  localparam int DB_EN = 1;
`else
  localparam int DB_EN = 0;
`endif
  localparam int LAT = 3 + DB_EN * (DB - 1);
  localparam int PW  = (DB_EN != 0) ? DB + 4 : 1;
  localparam int GAP = (DB_EN != 0) ? 2 * DB + 6 : 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    src_in = '0;
  logic [N-1:0]    src_mask = '1;
  logic [N-1:0]    overrun_clear = '0;
  logic            pend_ready = 1'b0;
  logic            pend_valid;
  logic [VecW-1:0] pend_id;
  logic [N-1:0]    overrun;

  int vectors = 0;
  int miscompares = 0;
  int n_acc = 0;
  int last_id = 0;
  int hold [N];

  // Behavioural model state
  logic [N-1:0]    m_s1, m_s2, m_f, m_fprev, m_pend, m_ovr;
  int              m_run [N];
  int              m_ptr;
  logic            m_valid;
  logic [VecW-1:0] m_id;

  typedef struct {
    logic [N-1:0]    src;
    logic            ready;
    logic            exp_valid;
    logic [VecW-1:0] exp_id;
    logic [N-1:0]    exp_ovr;
  } vec_t;
  vec_t tbl [LAT+3];

  ext_int_ctrl #(
    .NumSrc(N), .FirstId(FIRST), .DebounceCycles(DB)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .src_in       (src_in),
    .src_mask     (src_mask),
    .pend_valid   (pend_valid),
    .pend_id      (pend_id),
    .pend_ready   (pend_ready),
    .overrun      (overrun),
    .overrun_clear(overrun_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_f = '0; m_fprev = '0; m_pend = '0; m_ovr = '0;
    m_ptr = 0; m_valid = 1'b0; m_id = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  // One clock edge of the specified behaviour, using inputs stable before it.
  task automatic model_step();
    logic [N-1:0] rise, new_pend, new_ovr, new_f;
    int gnt;
    if (rst) begin
      model_reset();
      return;
    end
    rise = m_f & ~m_fprev;
    gnt  = -1;
    if (!m_valid || pend_ready) begin
      for (int d = 0; d < N; d++)
        if (gnt < 0 && m_pend[(m_ptr + d) % N]) gnt = (m_ptr + d) % N;
      if (gnt >= 0) begin
        m_valid = 1'b1;
        m_id    = VecW'(FIRST + gnt);
        m_ptr   = (gnt + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    new_pend = m_pend;
    new_ovr  = m_ovr & ~overrun_clear;
    if (gnt >= 0) new_pend[gnt] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rise[i] && src_mask[i]) begin
        if (m_pend[i] && gnt != i) new_ovr[i] = 1'b1;
        new_pend[i] = 1'b1;
      end
    end
    new_f = m_f;
`ifdef EXT_INT_DEBOUNCE_EN
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] != m_f[i]) begin
        m_run[i]++;
        if (m_run[i] == DB - 1) begin
          new_f[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
`else
    new_f = m_s1;  // filtered level is the second synchronizer stage
`endif
    m_fprev = m_f;
    m_f     = new_f;
    m_s2    = m_s1;
    m_s1    = src_in;
    m_pend  = new_pend;
    m_ovr   = new_ovr;
  endtask

  task automatic tick();
    logic acc;
    acc = pend_valid && pend_ready;
    @(posedge clk);
    model_step();
    #1;
    if (acc && !rst) begin
      n_acc++;
      $display("cmd id=%0d accepted t=%0t", last_id, $time);
    end
    check("model_valid", 32'(pend_valid), 32'(m_valid));
    check("model_id", 32'(pend_id), 32'(m_id));
    check("model_overrun", 32'(overrun), 32'(m_ovr));
    if (pend_valid) last_id = int'(pend_id);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    model_reset();
    src_in = '0; src_mask = '1; overrun_clear = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input int idx);
    src_in[idx] = 1'b1;
    repeat (PW) tick();
    src_in[idx] = 1'b0;
    repeat (GAP) tick();
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < LAT + 3; k++)
      tbl[k] = '{src: 4'b0001, ready: 1'b1, exp_valid: (k == LAT),
                 exp_id: (k >= LAT) ? VecW'(1) : VecW'(0), exp_ovr: 4'b0000};

    // Reset state
    repeat (2) tick();
    check("reset_valid", 32'(pend_valid), 32'd0);
    check("reset_id", 32'(pend_id), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;

    // Single source latency and release
    for (int k = 0; k < LAT + 3; k++) begin
      src_in = tbl[k].src;
      pend_ready = tbl[k].ready;
      tick();
      check("tbl_valid", 32'(pend_valid), 32'(tbl[k].exp_valid));
      check("tbl_id", 32'(pend_id), 32'(tbl[k].exp_id));
      check("tbl_overrun", 32'(overrun), 32'(tbl[k].exp_ovr));
    end

    // All sources at once: one command per cycle in order, then 1 and 3 again
    reset_dut();
    pend_ready = 1'b1;
    src_in = '1;
    for (int k = 0; k <= LAT + 4; k++) begin
      tick();
      if (k >= LAT && k < LAT + 4) begin
        check("rr_valid", 32'(pend_valid), 32'd1);
        check("rr_id", 32'(pend_id), 32'(FIRST + k - LAT));
      end
      if (k == LAT + 4) check("rr_done", 32'(pend_valid), 32'd0);
    end
    src_in = '0;
    repeat (GAP) tick();
    src_in = 4'b1010;
    for (int k = 0; k <= LAT + 2; k++) begin
      tick();
      if (k == LAT) check("rr2_first", 32'(pend_id), 32'd2);
      if (k == LAT + 1) check("rr2_second", 32'(pend_id), 32'd4);
      if (k == LAT + 2) check("rr2_done", 32'(pend_valid), 32'd0);
    end
    src_in = '0;
    repeat (GAP) tick();

    // Back-pressure and overrun: command held, second edge latched, third overruns
    reset_dut();
    pend_ready = 1'b0;
    repeat (3) pulse(2);
    check("bp_valid", 32'(pend_valid), 32'd1);
    check("bp_id", 32'(pend_id), 32'd3);
    check("bp_overrun", 32'(overrun[2]), 32'd1);
    overrun_clear[2] = 1'b1;
    tick();
    overrun_clear = '0;
    check("ovr_cleared", 32'(overrun[2]), 32'd0);
    n_acc = 0;
    pend_ready = 1'b1;
    repeat (6) tick();
    check("bp_cmds", 32'(n_acc), 32'd2);
    check("bp_idle", 32'(pend_valid), 32'd0);

    // Masking drops new edges but never a latched request
    reset_dut();
    pend_ready = 1'b1;
    src_mask = 4'b1101;
    n_acc = 0;
    pulse(1);
    check("mask_cmds", 32'(n_acc), 32'd0);
    check("mask_overrun", 32'(overrun), 32'd0);
    pend_ready = 1'b0;
    src_mask = '1;
    pulse(0);
    pulse(1);
    src_mask = 4'b1101;
    n_acc = 0;
    pend_ready = 1'b1;
    repeat (6) tick();
    check("mask_latched_cmds", 32'(n_acc), 32'd2);
    check("mask_latched_id", 32'(last_id), 32'd2);
    src_mask = '1;

    // Asynchronous reset with a command in flight and a request pending
    reset_dut();
    pend_ready = 1'b0;
    pulse(0);
    pulse(2);
    src_in[0] = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_valid", 32'(pend_valid), 32'd0);
    check("arst_id", 32'(pend_id), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    pend_ready = 1'b1;
    n_acc = 0;
    repeat (LAT + GAP) tick();
    check("arst_cmds", 32'(n_acc), 32'd1);
    check("arst_id_after", 32'(last_id), 32'd1);
    src_in = '0;
    repeat (GAP) tick();

`ifdef EXT_INT_DEBOUNCE_EN
    // Debounce: short glitch ignored, long pulse accepted, bouncing gives one event
    reset_dut();
    pend_ready = 1'b1;
    n_acc = 0;
    src_in[0] = 1'b1;
    repeat (10) tick();
    src_in[0] = 1'b0;
    repeat (GAP) tick();
    check("db_glitch_cmds", 32'(n_acc), 32'd0);
    src_in[0] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == LAT - 1) check("db_early", 32'(pend_valid), 32'd0);
      if (k == LAT) check("db_on_time", 32'(pend_valid), 32'd1);
    end
    src_in[0] = 1'b0;
    repeat (GAP) tick();
    n_acc = 0;
    for (int j = 0; j < 6; j++) begin
      src_in[0] = (j % 2 == 0);
      repeat (3) tick();
    end
    src_in[0] = 1'b1;
    repeat (30) tick();
    for (int j = 0; j < 6; j++) begin
      src_in[0] = (j % 2 == 1);
      repeat (3) tick();
    end
    src_in[0] = 1'b0;
    repeat (GAP) tick();
    check("db_bounce_cmds", 32'(n_acc), 32'd1);
`endif

    // Randomized traffic against the model
    reset_dut();
    for (int i = 0; i < N; i++) hold[i] = 0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          src_in[i] = ~src_in[i];
          hold[i] = $urandom_range(1, (DB_EN != 0) ? 40 : 5);
        end else begin
          hold[i]--;
        end
        src_mask[i] = ($urandom_range(0, 7) != 0);
      end
      pend_ready = ($urandom_range(0, 3) != 0);
      overrun_clear = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
